// File: rtl/rr_prio_arb.sv
// rr_prio_arb: N-way arbiter with a registered one-hot grant.
// The policy is selectable at runtime: fixed priority (bit 0 highest) or
// round-robin. The owner keeps the grant while it requests. When others
// are waiting, the owner can be preempted after MAX_HOLD cycles.

module rr_prio_arb #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rr_en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_vld,
    output logic           preempt
);

    // The hold counter only needs to reach MAX_HOLD-1. It keeps at least one bit.
    localparam int HCW = (MAX_HOLD > 0) ? (($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           preempt_q, preempt_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

    logic [N-1:0]   others;
    logic [N-1:0]   arb_mask;
    logic [IDW-1:0] win_idx;
    logic           owner_req;

    // Return the first set index of mask. In round-robin mode the search
    // starts at ptr and wraps. In fixed mode it starts at bit 0. The caller
    // guarantees that mask is non-zero.
    function automatic logic [IDW-1:0] pick(input logic [N-1:0]   mask,
                                            input logic           rr,
                                            input logic [IDW-1:0] ptr);
        logic [IDW-1:0] cur;
        logic [IDW-1:0] res;
        logic           found;
        cur   = rr ? ptr : '0;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && mask[cur]) begin
                res   = cur;
                found = 1'b1;
            end
            if (cur == LAST_ID) begin
                cur = '0;
            end else begin
                cur = cur + 1'b1;
            end
        end
        return res;
    endfunction

    // Requests competing with the current owner. The owner is masked out so
    // that it cannot win its own re-arbitration.
    always_comb begin
        others    = req & ~gnt_q;
        owner_req = |(req & gnt_q);
        arb_mask  = (state_q == IDLE) ? req : others;
        win_idx   = pick(arb_mask, rr_en, ptr_q);
    end

    // Next-state logic. It handles idle arbitration, hand-over on release,
    // preemption after a long hold, and the saturating hold counter.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        preempt_d  = 1'b0;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = GRANT;
                    gnt_d      = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    gnt_id_d   = win_idx;
                    hold_cnt_d = '0;
                    ptr_d      = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    if (|others) begin
                        gnt_d      = {{(N-1){1'b0}}, 1'b1} << win_idx;
                        gnt_id_d   = win_idx;
                        hold_cnt_d = '0;
                        ptr_d      = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = '0;
                        gnt_id_d   = '0;
                        hold_cnt_d = '0;
                    end
                end else if ((MAX_HOLD > 0) && (hold_cnt_q == HOLD_LAST) && (|others)) begin
                    gnt_d      = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    gnt_id_d   = win_idx;
                    preempt_d  = 1'b1;
                    hold_cnt_d = '0;
                    ptr_d      = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    // State and output registers. A synchronous reset drops any grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            preempt_q  <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            preempt_q  <= preempt_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = |gnt_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_prio_arb.sv
// tb_rr_prio_arb: directed and randomized checks of rr_prio_arb.
// A behavioural owner/pointer model built from the arbitration rules
// supplies the expected value of every output.

module tb_rr_prio_arb;

   localparam int N        = 4;
   localparam int MAX_HOLD = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       rr_en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_vld;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   // Reference model state. m_own is -1 when no requester holds the grant.
   int m_own  = -1;
   int m_ptr  = 0;
   int m_hold = 0;
   int m_pre  = 0;

   rr_prio_arb #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk),
      .rst(rst),
      .rr_en(rr_en),
      .req(req),
      .gnt(gnt),
      .gnt_id(gnt_id),
      .gnt_vld(gnt_vld),
      .preempt(preempt)
   );

   // Free-running clock with a 10 ns period.
   always #5 clk = ~clk;

   function automatic int modelWin(input logic [3:0] mask, input logic rr);
      int idx;
      for (int i = 0; i < N; i++) begin
         idx = rr ? ((m_ptr + i) % N) : i;
         if (mask[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic modelGrant(input int w, input int pre);
      m_own  = w;
      m_hold = 0;
      m_ptr  = (w + 1) % N;
      m_pre  = pre;
   endtask

   // Move the model forward by one clock edge, using the arbitration rules directly.
   task automatic modelStep(input logic r, input logic [3:0] rq, input logic rr);
      logic [3:0] oth;
      m_pre = 0;
      if (r) begin
         m_own  = -1;
         m_ptr  = 0;
         m_hold = 0;
      end else if (m_own < 0) begin
         if (rq != 4'b0000) modelGrant(modelWin(rq, rr), 0);
      end else begin
         oth = rq & ~(4'b0001 << m_own);
         if (!rq[m_own]) begin
            if (oth != 4'b0000) modelGrant(modelWin(oth, rr), 0);
            else begin
               m_own  = -1;
               m_hold = 0;
            end
         end else if (MAX_HOLD > 0 && m_hold == MAX_HOLD - 1 && oth != 4'b0000) begin
            modelGrant(modelWin(oth, rr), 1);
         end else if (m_hold < MAX_HOLD - 1) begin
            m_hold++;
         end
      end
   endtask

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      logic [3:0] eg;
      eg = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
      checkVal("model_gnt", 32'(gnt), 32'(eg));
      checkVal("model_gnt_id", 32'(gnt_id), (m_own < 0) ? 32'd0 : 32'(m_own));
      checkVal("model_gnt_vld", 32'(gnt_vld), (m_own < 0) ? 32'd0 : 32'd1);
      checkVal("model_preempt", 32'(preempt), 32'(m_pre));
   endtask

   // Drive inputs on the falling edge. After the rising edge, update the
   // model and sample the DUT 1 ns later.
   task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic rre);
      @(negedge clk);
      rst   = r;
      req   = rq;
      rr_en = rre;
      @(posedge clk);
      modelStep(r, rq, rre);
      #1;
      checkOutput();
   endtask

   initial begin
      logic [3:0] rq;
      logic [3:0] prev_gnt;
      logic [3:0] order[$];
      logic [3:0] exp_order[5];
      logic       rre;
      int         own_cycles;
      int         last_own;
      int         zero_cnt;
      int         pre_cnt;

      rst   = 1'b1;
      req   = 4'b0000;
      rr_en = 1'b0;

      // Reset held while all requesters are active.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1111, 1'b0);
      checkVal("reset_gnt", 32'(gnt), 32'd0);
      checkVal("reset_vld", 32'(gnt_vld), 32'd0);
      checkVal("reset_id", 32'(gnt_id), 32'd0);
      checkVal("reset_preempt", 32'(preempt), 32'd0);
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkVal("post_reset_gnt", 32'(gnt), 32'h1);

      // Fixed priority with preemption after MAX_HOLD cycles.
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 4'b1111, 1'b0);
      checkVal("fixed_hold_gnt", 32'(gnt), 32'h1);
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkVal("fixed_preempt1_gnt", 32'(gnt), 32'h2);
      checkVal("fixed_preempt1_pulse", 32'(preempt), 32'd1);
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 4'b1111, 1'b0);
      checkVal("fixed_pulse_once", 32'(preempt), 32'd0);
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkVal("fixed_preempt2_gnt", 32'(gnt), 32'h1);
      checkVal("fixed_preempt2_pulse", 32'(preempt), 32'd1);

      // Round-robin hand-over. Each owner drops its request after two cycles.
      applyStimulus(1'b1, 4'b1111, 1'b1);
      own_cycles = 0;
      last_own   = -1;
      zero_cnt   = 0;
      prev_gnt   = 4'b0000;
      for (int c = 0; c < 20 && order.size() < 5; c++) begin
         rq = 4'b1111;
         if (m_own >= 0 && own_cycles == 2) rq[m_own] = 1'b0;
         applyStimulus(1'b0, rq, 1'b1);
         if (gnt === 4'b0000) zero_cnt++;
         if (gnt !== prev_gnt) order.push_back(gnt);
         prev_gnt = gnt;
         if (m_own != last_own) own_cycles = 1;
         else own_cycles++;
         last_own = m_own;
      end
      exp_order[0] = 4'b0001;
      exp_order[1] = 4'b0010;
      exp_order[2] = 4'b0100;
      exp_order[3] = 4'b1000;
      exp_order[4] = 4'b0001;
      checkVal("rr_order_len", 32'(order.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (k < order.size()) checkVal("rr_order", 32'(order[k]), 32'(exp_order[k]));
      end
      checkVal("rr_no_bubble", 32'(zero_cnt), 32'd0);

      // A release with no other requesters returns the arbiter to idle.
      applyStimulus(1'b1, 4'b0000, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0100, 1'b0);
      checkVal("idle_held_gnt", 32'(gnt), 32'h4);
      applyStimulus(1'b0, 4'b0000, 1'b0);
      checkVal("idle_gnt", 32'(gnt), 32'h0);
      checkVal("idle_vld", 32'(gnt_vld), 32'd0);

      // A lone requester is never preempted. Its counter saturates.
      applyStimulus(1'b1, 4'b0000, 1'b0);
      pre_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 4'b1000, 1'b0);
         if (preempt === 1'b1) pre_cnt++;
      end
      checkVal("lone_no_preempt", 32'(pre_cnt), 32'd0);
      checkVal("lone_gnt", 32'(gnt), 32'h8);
      applyStimulus(1'b0, 4'b1001, 1'b0);
      checkVal("lone_preempt_gnt", 32'(gnt), 32'h1);
      checkVal("lone_preempt_pulse", 32'(preempt), 32'd1);

      // Reset in the middle of a grant in round-robin mode.
      applyStimulus(1'b1, 4'b0000, 1'b1);
      applyStimulus(1'b0, 4'b0100, 1'b1);
      applyStimulus(1'b0, 4'b0100, 1'b1);
      checkVal("midrst_owner", 32'(gnt), 32'h4);
      applyStimulus(1'b1, 4'b1111, 1'b1);
      checkVal("midrst_gnt", 32'(gnt), 32'h0);
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkVal("midrst_ptr_gnt", 32'(gnt), 32'h1);

      // Randomized traffic. Request bits toggle slowly so that long holds and
      // preemptions occur. The policy switches and resets happen occasionally.
      rq  = 4'($urandom_range(0, 15));
      rre = 1'b0;
      for (int c = 0; c < 600; c++) begin
         rq = rq ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 15) == 0) rre = ~rre;
         applyStimulus(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, rq, rre);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
